// File: rtl/sqrt_pkg.sv
// Shared types and arithmetic for the pipelined square root.
// Payloads are sized for the widest supported configuration (64-bit radicand, 16-bit tag).
package sqrt_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 64;
    localparam int unsigned MAX_TAG_WIDTH  = 16;

    function automatic int unsigned res_width(input int unsigned data_width);
        return data_width / 2;
    endfunction

    localparam int unsigned MAX_RES_WIDTH = res_width(MAX_DATA_WIDTH);
    localparam int unsigned MAX_REM_WIDTH = MAX_RES_WIDTH + 1;

    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] radicand;
        logic [MAX_RES_WIDTH-1:0]  root;
        logic [MAX_REM_WIDTH-1:0]  rem;
        logic [MAX_TAG_WIDTH-1:0]  tag;
    } stage_payload_t;

    typedef struct packed {
        logic                     root_bit;
        logic [MAX_REM_WIDTH-1:0] rem;
    } step_t;

    // Restoring trial subtract: (rem<<2 | bits) - (root<<2 | 1); a non-negative trial keeps the bit.
    function automatic step_t sqrt_step(input logic [MAX_REM_WIDTH-1:0] rem_in,
                                        input logic [MAX_RES_WIDTH-1:0] root_in,
                                        input logic [1:0]               bits);
        step_t                    s;
        logic [MAX_REM_WIDTH+1:0] cur;
        logic [MAX_REM_WIDTH+1:0] sub;
        cur        = {rem_in, bits};
        sub        = {1'b0, root_in, 2'b01};
        s.root_bit = (cur >= sub);
        s.rem      = s.root_bit ? MAX_REM_WIDTH'(cur - sub) : MAX_REM_WIDTH'(cur);
        return s;
    endfunction

endpackage

// File: rtl/sqrt_pipe_stage.sv
// One pipeline stage: resolves root bit STAGE_IDX and holds its slot until the next stage frees up.
module sqrt_pipe_stage
    import sqrt_pkg::*;
#(
    parameter int unsigned STAGE_IDX = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           adv_i,
    input  logic           vld_i,
    input  stage_payload_t payload_i,
    output logic           vld_o,
    output stage_payload_t payload_o
);

    step_t          step;
    stage_payload_t payload_d;
    stage_payload_t payload_q;
    logic           vld_q;

    // NOTE: every variable written here gets a full default first, so no latch can be inferred.
    always_comb begin
        step           = sqrt_step(payload_i.rem, payload_i.root,
                                   payload_i.radicand[2*STAGE_IDX +: 2]);
        payload_d      = payload_i;
        payload_d.root = (payload_i.root << 1) | MAX_RES_WIDTH'(step.root_bit);
        payload_d.rem  = step.rem;
    end

    // NOTE: state uses non-blocking assignments so all stages shift on the same edge without ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= 1'b0;
            payload_q <= '0;
        end else if (adv_i) begin
            vld_q <= vld_i;
            if (vld_i) begin
                payload_q <= payload_d;
            end
        end
    end

    assign vld_o     = vld_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/sqrt_pipe_param.sv
// Fully pipelined integer square root with remainder; one root bit per stage, per-stage flow control.
// Supports DATA_WIDTH up to 64 and TAG_WIDTH up to 16.
module sqrt_pipe_param
    import sqrt_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned TAG_WIDTH  = 4,
    localparam int unsigned RES_WIDTH  = res_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arg_vld,
    output logic                  arg_rdy,
    input  logic [DATA_WIDTH-1:0] arg,
    input  logic [TAG_WIDTH-1:0]  arg_tag,
    output logic                  res_vld,
    input  logic                  res_rdy,
    output logic [RES_WIDTH-1:0]  res,
    output logic [RES_WIDTH:0]    rem,
    output logic [TAG_WIDTH-1:0]  res_tag
);

    logic [RES_WIDTH-1:0] vld_q;
    logic [RES_WIDTH-1:0] vld_in;
    logic [RES_WIDTH:0]   adv;
    logic                 entry_vld;
    stage_payload_t       entry_payload;
    stage_payload_t       stage_in  [RES_WIDTH];
    stage_payload_t       stage_out [RES_WIDTH];
    logic                 unused_payload;

    // adv[k+1] belongs to stage k; adv[0] is the consumer's acceptance of the output slot.
    always_comb begin
        adv[0] = res_rdy;
        for (int k = 0; k < RES_WIDTH; k++) begin
            adv[k+1] = !vld_q[k] || adv[k];
        end
    end

    assign arg_rdy   = adv[RES_WIDTH];
    assign entry_vld = arg_vld && arg_rdy;

    always_comb begin
        entry_payload          = '0;
        entry_payload.radicand = MAX_DATA_WIDTH'(arg);
        entry_payload.tag      = MAX_TAG_WIDTH'(arg_tag);
    end

    for (genvar k = 0; k < RES_WIDTH; k++) begin : g_stage
        if (k == RES_WIDTH - 1) begin : g_entry
            assign stage_in[k] = entry_payload;
            assign vld_in[k]   = entry_vld;
        end else begin : g_body
            assign stage_in[k] = stage_out[k+1];
            assign vld_in[k]   = vld_q[k+1];
        end

        sqrt_pipe_stage #(
            .STAGE_IDX(k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv_i    (adv[k+1]),
            .vld_i    (vld_in[k]),
            .payload_i(stage_in[k]),
            .vld_o    (vld_q[k]),
            .payload_o(stage_out[k])
        );
    end

    assign res_vld        = vld_q[0];
    assign res            = stage_out[0].root[RES_WIDTH-1:0];
    assign rem            = stage_out[0].rem[RES_WIDTH:0];
    assign res_tag        = stage_out[0].tag[TAG_WIDTH-1:0];
    assign unused_payload = ^stage_out[0];

endmodule

// File: tb/tb_sqrt_pipe_param.sv
// Self-checking bench for sqrt_pipe_param at DATA_WIDTH 16 (main), 8, 4 and 32.
module tb_sqrt_pipe_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 16-bit instance
    logic        a_vld, a_rdy, r_vld, r_rdy;
    logic [15:0] a;
    logic [3:0]  a_tag, r_tag;
    logic [7:0]  r;
    logic [8:0]  rm;
    // 8-bit instance
    logic        b_vld, b_rdy, b_res_vld, b_res_rdy;
    logic [7:0]  b_arg;
    logic [3:0]  b_tag, b_rtag;
    logic [3:0]  b_res;
    logic [4:0]  b_rem;
    // 4-bit instance
    logic        c_vld, c_rdy, c_res_vld, c_res_rdy;
    logic [3:0]  c_arg;
    logic [3:0]  c_tag, c_rtag;
    logic [1:0]  c_res;
    logic [2:0]  c_rem;
    // 32-bit instance
    logic        d_vld, d_rdy, d_res_vld, d_res_rdy;
    logic [31:0] d_arg;
    logic [3:0]  d_tag, d_rtag;
    logic [15:0] d_res;
    logic [16:0] d_rem;

    sqrt_pipe_param #(.DATA_WIDTH(16), .TAG_WIDTH(4)) u_dut16 (
        .clk(clk), .rst(rst), .arg_vld(a_vld), .arg_rdy(a_rdy), .arg(a), .arg_tag(a_tag),
        .res_vld(r_vld), .res_rdy(r_rdy), .res(r), .rem(rm), .res_tag(r_tag));
    sqrt_pipe_param #(.DATA_WIDTH(8), .TAG_WIDTH(4)) u_dut8 (
        .clk(clk), .rst(rst), .arg_vld(b_vld), .arg_rdy(b_rdy), .arg(b_arg), .arg_tag(b_tag),
        .res_vld(b_res_vld), .res_rdy(b_res_rdy), .res(b_res), .rem(b_rem), .res_tag(b_rtag));
    sqrt_pipe_param #(.DATA_WIDTH(4), .TAG_WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .arg_vld(c_vld), .arg_rdy(c_rdy), .arg(c_arg), .arg_tag(c_tag),
        .res_vld(c_res_vld), .res_rdy(c_res_rdy), .res(c_res), .rem(c_rem), .res_tag(c_rtag));
    sqrt_pipe_param #(.DATA_WIDTH(32), .TAG_WIDTH(4)) u_dut32 (
        .clk(clk), .rst(rst), .arg_vld(d_vld), .arg_rdy(d_rdy), .arg(d_arg), .arg_tag(d_tag),
        .res_vld(d_res_vld), .res_rdy(d_res_rdy), .res(d_res), .rem(d_rem), .res_tag(d_rtag));

    typedef struct {
        longint unsigned arg;
        logic [3:0]      tag;
    } op_t;

    op_t q16[$];
    op_t q8[$];
    op_t q4[$];
    op_t q32[$];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference floor(sqrt(v)) from real arithmetic, corrected to the exact integer.
    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned rt;
        rt = longint'($rtoi($sqrt(real'(v))));
        while (rt * rt > v) rt--;
        while ((rt + 1) * (rt + 1) <= v) rt++;
        return rt;
    endfunction

    task automatic check_result(input string name, input op_t op, input logic [63:0] res_o,
                                input logic [63:0] rem_o, input logic [3:0] tag_o);
        longint unsigned rt;
        rt = isqrt(op.arg);
        check({name, ".res"}, res_o, rt);
        check({name, ".rem"}, rem_o, op.arg - rt * rt);
        check({name, ".tag"}, tag_o, op.tag);
        check({name, ".identity"}, res_o * res_o + rem_o, op.arg);
        check({name, ".rem_bound"}, 64'(rem_o <= 2 * res_o), 64'd1);
    endtask

    // Scoreboards: record accepted operands, compare every consumed result in acceptance order.
    always @(negedge clk) begin
        if (rst) begin
            q16.delete(); q8.delete(); q4.delete(); q32.delete();
        end else begin
            if (r_vld && r_rdy) begin
                check("w16.pending", 64'(q16.size() != 0), 64'd1);
                if (q16.size() != 0) check_result("w16", q16.pop_front(), r, rm, r_tag);
            end
            if (a_vld && a_rdy) q16.push_back('{arg: 64'(a), tag: a_tag});
            if (b_res_vld && b_res_rdy) begin
                check("w8.pending", 64'(q8.size() != 0), 64'd1);
                if (q8.size() != 0) check_result("w8", q8.pop_front(), b_res, b_rem, b_rtag);
            end
            if (b_vld && b_rdy) q8.push_back('{arg: 64'(b_arg), tag: b_tag});
            if (c_res_vld && c_res_rdy) begin
                check("w4.pending", 64'(q4.size() != 0), 64'd1);
                if (q4.size() != 0) check_result("w4", q4.pop_front(), c_res, c_rem, c_rtag);
            end
            if (c_vld && c_rdy) q4.push_back('{arg: 64'(c_arg), tag: c_tag});
            if (d_res_vld && d_res_rdy) begin
                check("w32.pending", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) check_result("w32", q32.pop_front(), d_res, d_rem, d_rtag);
            end
            if (d_vld && d_rdy) q32.push_back('{arg: 64'(d_arg), tag: d_tag});
        end
    end

    task automatic send16(input logic [15:0] v, input logic [3:0] t);
        int n = 0;
        a = v; a_tag = t; a_vld = 1'b1;
        @(negedge clk);
        while (!a_rdy && n < 100) begin @(negedge clk); n++; end
        check("send16.accept", a_rdy, 1'b1);
        @(posedge clk); #1;
        a_vld = 1'b0;
    endtask

    task automatic send32(input logic [31:0] v, input logic [3:0] t);
        int n = 0;
        d_arg = v; d_tag = t; d_vld = 1'b1;
        @(negedge clk);
        while (!d_rdy && n < 100) begin @(negedge clk); n++; end
        check("send32.accept", d_rdy, 1'b1);
        @(posedge clk); #1;
        d_vld = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, got, n, idx, n_acc, stale;
        bit          have_snap;
        logic [7:0]  snap_r;
        logic [8:0]  snap_rm;
        logic [3:0]  snap_tag;
        logic [7:0]  gr[5];
        logic [8:0]  grm[5];
        logic [3:0]  gt[5];
        int          gc[5];
        int          exp_r[5]  = '{0, 1, 12, 14, 255};
        int          exp_rm[5] = '{0, 0, 0, 4, 510};

        rst = 1'b1;
        a_vld = 1'b0; a = '0; a_tag = '0; r_rdy = 1'b1;
        b_vld = 1'b0; b_arg = '0; b_tag = '0; b_res_rdy = 1'b1;
        c_vld = 1'b0; c_arg = '0; c_tag = '0; c_res_rdy = 1'b1;
        d_vld = 1'b0; d_arg = '0; d_tag = '0; d_res_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.res_vld", r_vld, 1'b0);
        check("reset.res", r, 8'd0);
        check("reset.rem", rm, 9'd0);
        check("reset.res_tag", r_tag, 4'd0);
        check("reset.arg_rdy", a_rdy, 1'b1);
        check("reset.res_vld8", b_res_vld, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency: accepted at edge N, valid after edge N+7.
        send16(16'd49, 4'd7);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!r_vld && lat < 30);
        check("latency", lat, 7);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back directed values, output must be contiguous.
        send16(16'd0, 4'd1); send16(16'd1, 4'd2); send16(16'd144, 4'd3);
        send16(16'd200, 4'd4); send16(16'd65535, 4'd5);
        got = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r_vld) begin
                if (got < 5) begin gr[got] = r; grm[got] = rm; gt[got] = r_tag; gc[got] = i; end
                got++;
            end
        end
        check("b2b.count", got, 5);
        check("b2b.contiguous", gc[4] - gc[0], 4);
        for (int i = 0; i < 5; i++) begin
            check("b2b.res", gr[i], 64'(exp_r[i]));
            check("b2b.rem", grm[i], 64'(exp_rm[i]));
            check("b2b.tag", gt[i], 64'(i + 1));
        end
        @(posedge clk); #1;

        // Stall: capacity of 8, stable output, release accepts and drains in the same cycle.
        r_rdy = 1'b0; a_vld = 1'b1; a = 16'($urandom); a_tag = 4'($urandom);
        n_acc = 0; have_snap = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (a_rdy) n_acc++;
            if (r_vld && !have_snap) begin
                have_snap = 1'b1; snap_r = r; snap_rm = rm; snap_tag = r_tag;
            end
            @(posedge clk); #1;
            a = 16'($urandom); a_tag = 4'($urandom);
        end
        @(negedge clk);
        check("stall.acceptances", n_acc, 8);
        check("stall.arg_rdy_low", a_rdy, 1'b0);
        check("stall.res_vld", r_vld, 1'b1);
        check("stall.res_stable", r, snap_r);
        check("stall.rem_stable", rm, snap_rm);
        check("stall.tag_stable", r_tag, snap_tag);
        @(posedge clk); #1;
        r_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("stall.drain_vld", r_vld, 1'b1);
            if (i == 0) check("stall.rdy_same_cycle", a_rdy, 1'b1);
            @(posedge clk); #1;
            a = 16'($urandom); a_tag = 4'($urandom);
        end
        a_vld = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("stall.drained", q16.size(), 0);

        // Bubbles: sparse arrivals while stalled must leave back-to-back.
        r_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send16(16'($urandom), 4'(i + 8));
            repeat (2) @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        r_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bubble.vld", r_vld, 1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bubble.after", r_vld, 1'b0);
        @(posedge clk); #1;

        // Reset with operands in flight.
        r_rdy = 1'b0;
        for (int i = 0; i < 5; i++) send16(16'($urandom), 4'(i));
        repeat (6) @(posedge clk);
        #1;
        check("rst.pre_vld", r_vld, 1'b1);
        rst = 1'b1;
        #1;
        check("rst.res_vld", r_vld, 1'b0);
        check("rst.arg_rdy", a_rdy, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0; r_rdy = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); if (r_vld) stale++; end
        check("rst.no_stale", stale, 0);
        @(posedge clk); #1;
        send16(16'd81, 4'hA);
        n = 0;
        do begin @(negedge clk); n++; end while (!r_vld && n < 20);
        check("rst.after_res", r, 8'd9);
        check("rst.after_rem", rm, 9'd0);
        check("rst.after_tag", r_tag, 4'hA);
        @(posedge clk); #1;

        // Random traffic, random backpressure.
        idx = 0; n = 0;
        while (idx < 300 && n < 4000) begin
            a_vld = 1'($urandom_range(0, 1)); a = 16'($urandom); a_tag = 4'($urandom);
            r_rdy = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (a_vld && a_rdy) idx++;
            @(posedge clk); #1;
            n++;
        end
        check("rand16.sent", idx, 300);
        a_vld = 1'b0; r_rdy = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("rand16.drained", q16.size(), 0);

        // Exhaustive 8-bit.
        idx = 0; n = 0;
        while (idx < 256 && n < 3000) begin
            b_vld = ($urandom_range(0, 3) != 0); b_arg = 8'(idx); b_tag = 4'($urandom);
            b_res_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (b_vld && b_rdy) idx++;
            @(posedge clk); #1;
            n++;
        end
        check("w8.sent", idx, 256);
        b_vld = 1'b0; b_res_rdy = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("w8.drained", q8.size(), 0);

        // Exhaustive 4-bit.
        idx = 0; n = 0;
        while (idx < 16 && n < 500) begin
            c_vld = ($urandom_range(0, 3) != 0); c_arg = 4'(idx); c_tag = 4'($urandom);
            c_res_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (c_vld && c_rdy) idx++;
            @(posedge clk); #1;
            n++;
        end
        check("w4.sent", idx, 16);
        c_vld = 1'b0; c_res_rdy = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("w4.drained", q4.size(), 0);

        // 32-bit corner values plus random.
        send32(32'hFFFF_FFFF, 4'd1);
        send32(32'h4000_0000, 4'd2);
        n = 0;
        do begin @(negedge clk); n++; end while (!d_res_vld && n < 40);
        check("w32.max_res", d_res, 16'd65535);
        check("w32.max_rem", d_rem, 17'd131070);
        @(negedge clk);
        check("w32.pow_vld", d_res_vld, 1'b1);
        check("w32.pow_res", d_res, 16'd32768);
        check("w32.pow_rem", d_rem, 17'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) send32($urandom, 4'($urandom));
        repeat (20) @(posedge clk);
        #1;
        check("w32.drained", q32.size(), 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sqrt_pipe_param.md
# sqrt_pipe_param

Parametrised, fully pipelined integer square root with a valid/ready handshake on both sides. One pipeline stage resolves one result bit (restoring digit recurrence), and the block also returns the remainder. Stages hold their data under output backpressure and collapse bubbles. It sits between a streaming producer and consumer in the datapath, as the general-width, flow-controlled successor to the fixed 8-bit sqrt pipeline.

## Interface
- DATA_WIDTH, 16, radicand width; must be even and ≥4.
- TAG_WIDTH, 4, opaque sideband carried alongside each operand; must be ≥1.
- RES_WIDTH, DATA_WIDTH/2, derived (localparam); root width.
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- arg_vld  in  1  operand valid.
- arg_rdy  out  1  block can accept an operand this cycle.
- arg  in  DATA_WIDTH  unsigned radicand.
- arg_tag  in  TAG_WIDTH  sideband, returned unchanged with the result.
- res_vld  out  1  result valid.
- res_rdy  in  1  consumer accepts the result.
- res  out  RES_WIDTH  floor(sqrt(arg)).
- rem  out  RES_WIDTH+1  arg − res².
- res_tag  out  TAG_WIDTH  tag of the operand producing res.

## Operation
- Pipeline of RES_WIDTH stages, S[RES_WIDTH−1] down to S[0]. Each stage holds: vld, radicand (remaining low bits), partial root, partial remainder, tag.
- Stage k works on bit k. It computes trial = (rem_in<<2 | next 2 radicand bits) − (root_in<<2 | 1), using RES_WIDTH+2-bit signed arithmetic.
  - If trial ≥ 0: root bit = 1 and rem_out = trial.
  - Otherwise: root bit = 0 and rem_out = (rem_in<<2 | bits).
- The first stage takes root_in = 0 and rem_in = 0.
- Invariants on the output: arg = res² + rem, and rem ≤ 2·res.
- Flow control is per stage.
  - adv[k] = !vld[k] || adv[k−1].
  - adv of the last stage = !res_vld || res_rdy.
  - A stage loads when adv[k] is high. It loads vld from the previous stage's vld, or for the entry stage from arg_vld && arg_rdy.
  - Bubbles are squeezed out even while the output is stalled.
- arg_rdy = adv of the entry stage. It is combinational from res_rdy and the vld bits. arg_vld never feeds arg_rdy.
- The output register is the final stage: res, rem and res_tag are registered. They hold stable while res_vld && !res_rdy.
- Data registers load only when their stage advances with valid input. Invalid slots are not cleared, so their contents are don't-care.

## Timing
- Reset (async assert, sync deassert handled upstream): all vld flops, res_vld, res, rem and res_tag go to 0. arg_rdy is 1 one gate-delay after the vld bits clear.
- Latency: an operand accepted at edge N (arg_vld && arg_rdy) gives res_vld = 1 after edge N+RES_WIDTH−1, which is RES_WIDTH register stages including the output register.
- Throughput: one result per cycle while res_rdy stays high.
- Capacity: RES_WIDTH operands in flight. With res_rdy held low, arg_rdy falls after RES_WIDTH acceptances.
- When res_rdy rises on a full pipe, arg_rdy rises in the same cycle. A new operand is accepted on the same edge that the head result is consumed.
- Reset during operation drops every in-flight operand. No result is produced for operands accepted before reset.
- Ordering: results and tags leave strictly in acceptance order.

## Structure
- Package sqrt_pkg holds:
  - res_width(data_width) constant function;
  - stage payload struct type (radicand, root, rem, tag), parametrised through the package's localparam-driven widths;
  - sqrt_step function implementing the trial subtract.
- Sub-module sqrt_pipe_stage holds one stage's registers and advance logic. It is instantiated RES_WIDTH times through a generate loop, with a stage-index parameter selecting its radicand bits.
- The top level holds only the generate loop, the adv chain and the output port mapping.

## Test plan
- DATA_WIDTH=16, res_rdy=1. Send 0, 1, 144, 200, 65535 back-to-back with tags 1–5. Expected, in order: (0,0,t1), (1,0,t2), (12,0,t3), (14,4,t4), (255,510,t5). First res_vld appears 7 cycles after the first acceptance edge.
- Stall: hold res_rdy=0 with arg_vld=1 continuously. arg_rdy must drop after exactly 8 acceptances. res, rem and res_tag stay stable. Raise res_rdy: 8 results drain in order at 1 per cycle, and a new operand is accepted in the same cycle.
- Bubbles: send operands every 3rd cycle with res_rdy=0, then release. Results must come out back-to-back with no gaps and in order.
- Reset mid-stream: assert rst for 1 cycle with 5 operands in flight. res_vld must go 0 immediately and no stale result may appear. A following operand 81 returns (9,0).
- Exhaustive at DATA_WIDTH=8: all 256 values with random res_rdy and random arg_vld. Check res² + rem = arg and rem ≤ 2·res against a scoreboard model.
- Width sweep: DATA_WIDTH=4 and 32. For 32, check 0xFFFFFFFF → (65535, 131070) and 2³⁰ → (32768, 0).
